serial_demultiplexer: RTL and testbench

//  Receive end of the select-driven serial link: a time-multiplexed bit stream
//  is deserialized into WIDTH-bit words, and each word is routed to channel 0
//  or channel 1. The channel is chosen by s, sampled on the first bit of each

---
 rtl/serial_demultiplexer.sv | 109 ++++++++++
 tb/tb_serial_demultiplexer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_demultiplexer.sv
// Serial-to-parallel receiver that routes each completed word to one of two
// channels selected by s on the word's first bit.
module serial_demultiplexer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    output logic [WIDTH-1:0] out,
    output logic             valid0,
    output logic             valid1,
    input  logic             ready0,
    input  logic             ready1
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] out_d;
    logic             sel_q, sel_d;
    logic             valid0_d, valid1_d;
    logic             accept;
    logic             release_word;

    // Accept only while collecting and never while reset is asserted.
    assign in_ready = (state == COLLECT) && !rst;
    assign accept   = in_valid && in_ready;

    // Handshake on the selected channel only; the other ready is ignored.
    assign release_word = (valid0 && ready0) || (valid1 && ready1);

    // Next-state and datapath updates; every target defaults to hold.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        shreg_d  = shreg;
        out_d    = out;
        sel_d    = sel_q;
        valid0_d = valid0;
        valid1_d = valid1;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    shreg_d[cnt] = in_bit;
                    if (cnt == '0) begin
                        sel_d = s;
                    end
                    if (cnt == LAST) begin
                        out_d   = {in_bit, shreg[WIDTH-2:0]};
                        cnt_d   = '0;
                        state_d = HOLD;
                        // A 1-bit word would need s itself; otherwise sel_q
                        // already holds the value from bit 0.
                        if (sel_q) begin
                            valid1_d = 1'b1;
                        end else begin
                            valid0_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (release_word) begin
                    valid0_d = 1'b0;
                    valid1_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COLLECT;
            cnt    <= '0;
            shreg  <= '0;
            out    <= '0;
            sel_q  <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            shreg  <= shreg_d;
            out    <= out_d;
            sel_q  <= sel_d;
            valid0 <= valid0_d;
            valid1 <= valid1_d;
        end
    end

endmodule

// File: tb/tb_serial_demultiplexer.sv
// Directed bench for serial_demultiplexer with WIDTH=8.
module tb_serial_demultiplexer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic         s;
    logic [W-1:0] out;
    logic         valid0;
    logic         valid1;
    logic         ready0;
    logic         ready1;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_demultiplexer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .out      (out),
        .valid0   (valid0),
        .valid1   (valid1),
        .ready0   (ready0),
        .ready1   (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit for one edge; returns 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic sel);
        in_valid = 1'b1;
        in_bit   = b;
        s        = sel;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send bits [first..last] of d LSB-first; s=s0 on bit 0, else s_rest.
    task automatic send_bits(input logic [W-1:0] d, input int first,
                             input int last, input logic s0,
                             input logic s_rest);
        for (int i = first; i <= last; i++) begin
            send_bit(d[i], (i == 0) ? s0 : s_rest);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_cmp++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 00", out);
        end
        n_cmp++;
        if ({valid0, valid1} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 00", {valid0, valid1});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_ch0;
        ready0 = 1'b1;
        send_bits(8'hA5, 0, 7, 1'b0, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b1 || out !== 8'hA5) begin
            n_fail++;
            $display("FAIL t1_word: got v0=%b out=%h want v0=1 out=a5",
                     valid0, out);
        end
        n_cmp++;
        if (valid1 !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_side: got v1=%b rdy=%b want v1=0 rdy=0",
                     valid1, in_ready);
        end
        idle(1);
        n_cmp++;
        if (valid0 !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_release: got v0=%b rdy=%b want v0=0 rdy=1",
                     valid0, in_ready);
        end
        ready0 = 1'b0;
    endtask

    task automatic test_hold_ch1;
        ready1 = 1'b0;
        send_bits(8'h3C, 0, 7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (valid1 !== 1'b1 || valid0 !== 1'b0 || out !== 8'h3C ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL t2_hold%0d: got v1=%b v0=%b out=%h rdy=%b want 1 0 3c 0",
                         i, valid1, valid0, out, in_ready);
            end
            idle(1);
        end
    endtask

    task automatic test_wrong_ready;
        ready0 = 1'b1;
        idle(1);
        ready0 = 1'b0;
        n_cmp++;
        if (valid1 !== 1'b1 || valid0 !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_no_release: got v1=%b v0=%b rdy=%b want 1 0 0",
                     valid1, valid0, in_ready);
        end
        ready1 = 1'b1;
        idle(1);
        ready1 = 1'b0;
        n_cmp++;
        if (valid1 !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_release: got v1=%b rdy=%b want 0 1",
                     valid1, in_ready);
        end
    endtask

    task automatic test_gap;
        send_bits(8'hF0, 0, 3, 1'b0, 1'b1);
        idle(3);
        n_cmp++;
        if (out !== 8'h3C || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_gap: got out=%h v0=%b want 3c 0", out, valid0);
        end
        send_bits(8'hF0, 4, 6, 1'b0, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b0 || valid1 !== 1'b0 || out !== 8'h3C) begin
            n_fail++;
            $display("FAIL t4_early: got v0=%b v1=%b out=%h want 0 0 3c",
                     valid0, valid1, out);
        end
        send_bits(8'hF0, 7, 7, 1'b0, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b1 || valid1 !== 1'b0 || out !== 8'hF0) begin
            n_fail++;
            $display("FAIL t4_word: got v0=%b v1=%b out=%h want 1 0 f0",
                     valid0, valid1, out);
        end
        ready0 = 1'b1;
        idle(1);
        ready0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        send_bits(8'hFF, 0, 3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out !== 8'h00 || valid0 !== 1'b0 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset: got out=%h v0=%b v1=%b want 00 0 0",
                     out, valid0, valid1);
        end
        idle(1);
        rst = 1'b0;
        send_bits(8'h01, 0, 7, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 8'h01 || valid1 !== 1'b1 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_word: got out=%h v1=%b v0=%b want 01 1 0",
                     out, valid1, valid0);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (valid1 !== 1'b0 || out !== 8'h00) begin
            n_fail++;
            $display("FAIL t5_async_hold: got v1=%b out=%h want 0 00",
                     valid1, out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back;
        ready0 = 1'b1;
        ready1 = 1'b1;
        send_bits(8'h12, 0, 7, 1'b0, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b1 || valid1 !== 1'b0 || out !== 8'h12) begin
            n_fail++;
            $display("FAIL t6_first: got v0=%b v1=%b out=%h want 1 0 12",
                     valid0, valid1, out);
        end
        // Offer a bit during the handshake edge; it must not be taken.
        send_bit(1'b1, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_bubble: got v0=%b rdy=%b want 0 1",
                     valid0, in_ready);
        end
        send_bits(8'h34, 0, 7, 1'b1, 1'b0);
        n_cmp++;
        if (valid1 !== 1'b1 || valid0 !== 1'b0 || out !== 8'h34) begin
            n_fail++;
            $display("FAIL t6_second: got v1=%b v0=%b out=%h want 1 0 34",
                     valid1, valid0, out);
        end
        idle(1);
        n_cmp++;
        if (valid1 !== 1'b0 || in_ready !== 1'b1 || out !== 8'h34) begin
            n_fail++;
            $display("FAIL t6_release: got v1=%b rdy=%b out=%h want 0 1 34",
                     valid1, in_ready, out);
        end
        ready0 = 1'b0;
        ready1 = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        s        = 1'b0;
        ready0   = 1'b0;
        ready1   = 1'b0;
        test_reset();
        test_basic_ch0();
        test_hold_ch1();
        test_wrong_ready();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
